uart_tx_scheduler: RTL and testbench
====================================

# uart_tx_scheduler

Shares the single `uart_transmitter` between two byte producers: the counter's status byte (requester 0) and the receive-path echo (requester 1). Each requester has a one-byte holding buffer behind a valid/ready handshake. The block arbitrates round-robin and issues one start pulse per byte. Because the transmitter exposes no busy flag, the block times each frame itself. It sits between the producers and `uart_tx`, driving that instance's `i_data` and `i_start_transmission`.

## Interface
- `CLKS_PER_BIT`, default 868: clocks per UART bit; must match `uart_transmitter`.
- `FRAME_BITS`, default 10: bits per frame (start + 8 data + stop).
- `GAP_CLKS`, default 16: idle clocks enforced after each frame; legal range ≥1.
- `clk` in 1: system clock (`clk_gen` domain).
- `i_reset` in 1: asynchronous, active-low reset.
- `i_req0_valid` in 1: requester 0 offers a byte.
- `i_req0_data` in [0:7]: requester 0 byte.
- `o_req0_ready` out 1: requester 0 buffer empty; a byte is accepted on a clk edge where valid && ready.
- `i_req1_valid` in 1: requester 1 offers a byte.
- `i_req1_data` in [0:7]: requester 1 byte.
- `o_req1_ready` out 1: requester 1 buffer empty.
- `o_uart_data` out [0:7]: byte to transmitter; held stable from START through end of WAIT.
- `o_start_uart` out 1: single-cycle start pulse to transmitter.
- `o_busy` out 1: high in START, WAIT and GAP.
- `o_grant` out 1: requester index of the byte currently or most recently sent.

## Operation
- Buffers: each buffer is one byte plus a full flag; `o_reqN_ready` = !fullN (registered flag, no combinational path from valid).
  - Accept: on an edge with valid && ready, capture the data and set full.
  - Release: full clears on the edge leaving START for the granted requester.
- FSM states: IDLE, START, WAIT, GAP.
  - IDLE: if any buffer is full → START at the next edge. Latch the winner's byte into `o_uart_data` and set `o_grant`.
  - Arbitration with one buffer full: that requester wins.
  - Arbitration with both full: the requester opposite the last grant wins. The last grant is tracked in the registered `o_grant`, which resets to 1, so requester 0 wins first after reset.
  - START: `o_start_uart`=1 for exactly this cycle → WAIT. The counter loads CLKS_PER_BIT*FRAME_BITS−1.
  - WAIT: the counter decrements each cycle; at 0 → GAP with counter = GAP_CLKS−1.
  - GAP: the counter decrements; at 0, if any buffer is full, perform IDLE arbitration and go → START directly; otherwise → IDLE.
- Counter width: $clog2(CLKS_PER_BIT*FRAME_BITS); the counter never wraps because it is reloaded on every state entry.
- Boundary rules:
  - A requester may refill its buffer during WAIT or GAP; it is then eligible at the next arbitration.
  - A held byte is never dropped or overwritten while full=1.
  - Valid while ready=0 is ignored; the requester must hold it.
  - Reset assertion mid-frame: the FSM returns to IDLE immediately and both buffers clear. The transmitter is reset by the same `i_reset`, so no partial frame continues.

## Timing
- Values under reset: state IDLE, `o_start_uart`=0, `o_busy`=0, `o_uart_data`=8'h00, `o_grant`=1, `o_req0_ready`=`o_req1_ready`=1, both full flags 0.
- Latency from idle: valid && ready sampled at edge E → full at E → IDLE sees it in the cycle after E → `o_start_uart` high in the second cycle after E.
- `o_reqN_ready` rises in the first WAIT cycle for the granted requester.
- Back-to-back pulse spacing: 1 + CLKS_PER_BIT*FRAME_BITS + GAP_CLKS cycles.
- `o_busy` stays high continuously across back-to-back frames.

## Test plan
- Reset state: hold `i_reset`=0 → all outputs at the values listed under Timing. Release, then idle 100 cycles → no `o_start_uart` pulse.
- Single byte: CLKS_PER_BIT=4, GAP_CLKS=2; req0 sends 8'hA5 → `o_start_uart` 2 cycles after acceptance. `o_uart_data`=8'hA5 through 40 WAIT cycles; `o_busy` high 43 cycles; `o_grant`=0.
- Contention: both buffers loaded in the same cycle with 8'h11/8'h22 → 8'h11 sent first, then 8'h22. Start pulses are exactly 43 cycles apart; grant sequence 0,1.
- Fairness: both requesters keep their buffers full for 6 bytes → grants alternate 0,1,0,1,0,1; no byte is lost or duplicated.
- Backpressure: req1 holds valid during its full period with a changing data value → only the first byte is captured; ready stays 0 until START leaves.
- Reset mid-frame: assert `i_reset` at WAIT cycle 20 → `o_busy`=0 immediately, both ready=1; a new byte after release starts normally.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// Producer-side handshakes and transmitter drive signals of the UART TX scheduler.
// The scheduler uses the slave modport; the environment driving requesters uses master.
interface uart_tx_scheduler_if;
  logic       i_req0_valid;
  logic [0:7] i_req0_data;
  logic       o_req0_ready;
  logic       i_req1_valid;
  logic [0:7] i_req1_data;
  logic       o_req1_ready;
  logic [0:7] o_uart_data;
  logic       o_start_uart;
  logic       o_busy;
  logic       o_grant;

  modport slave (
    input  i_req0_valid, i_req0_data, i_req1_valid, i_req1_data,
    output o_req0_ready, o_req1_ready, o_uart_data, o_start_uart, o_busy, o_grant
  );

  modport master (
    output i_req0_valid, i_req0_data, i_req1_valid, i_req1_data,
    input  o_req0_ready, o_req1_ready, o_uart_data, o_start_uart, o_busy, o_grant
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter between two single-byte holding buffers.
// The transmitter has no busy flag, so each frame plus an idle gap is timed locally.
module uart_tx_scheduler #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FRAME_BITS   = 10,
  parameter int GAP_CLKS     = 16
) (
  input  logic                   clk,
  input  logic                   i_reset,
  uart_tx_scheduler_if.slave     bus
);

  localparam int FRAME_CLKS = CLKS_PER_BIT * FRAME_BITS;
  localparam int CNT_W      = $clog2(FRAME_CLKS);
  localparam logic [CNT_W-1:0] FRAME_LOAD = CNT_W'(FRAME_CLKS - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CLKS - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, GAP} state_t;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [0:7]       data_reg;
  logic             start_reg;
  logic             busy_reg;
  logic             grant_reg;

  logic [1:0]       valid_in;
  logic [0:7]       data_in   [2];
  logic [1:0]       full;
  logic [0:7]       hold_data [2];
  logic             any_full;
  logic             winner;
  logic             launch;

  assign valid_in   = {bus.i_req1_valid, bus.i_req0_valid};
  assign data_in[0] = bus.i_req0_data;
  assign data_in[1] = bus.i_req1_data;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_buf
      logic       full_reg;
      logic [0:7] hold_reg;

      // A full buffer ignores valid; it empties only as its frame leaves START.
      always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
          full_reg <= 1'b0;
          hold_reg <= '0;
        end else if (valid_in[gi] && !full_reg) begin
          full_reg <= 1'b1;
          hold_reg <= data_in[gi];
        end else if (state_reg == START && grant_reg == 1'(gi)) begin
          full_reg <= 1'b0;
        end
      end

      assign full[gi]      = full_reg;
      assign hold_data[gi] = hold_reg;
    end
  endgenerate

  // With both buffers full the requester opposite the last grant wins.
  assign any_full = |full;
  assign winner   = (full[0] && full[1]) ? ~grant_reg : full[1];
  assign launch   = any_full && (state_reg == IDLE || (state_reg == GAP && cnt_reg == '0));

  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      data_reg  <= '0;
      start_reg <= 1'b0;
      busy_reg  <= 1'b0;
      grant_reg <= 1'b1;
    end else if (launch) begin
      state_reg <= START;
      start_reg <= 1'b1;
      busy_reg  <= 1'b1;
      grant_reg <= winner;
      data_reg  <= hold_data[winner];
    end else begin
      case (state_reg)
        START: begin
          start_reg <= 1'b0;
          state_reg <= WAIT;
          cnt_reg   <= FRAME_LOAD;
        end
        WAIT: begin
          if (cnt_reg == '0) begin
            state_reg <= GAP;
            cnt_reg   <= GAP_LOAD;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        GAP: begin
          if (cnt_reg == '0) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg - CNT_W'(1);
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.o_req0_ready = !full[0];
  assign bus.o_req1_ready = !full[1];
  assign bus.o_uart_data  = data_reg;
  assign bus.o_start_uart = start_reg;
  assign bus.o_busy       = busy_reg;
  assign bus.o_grant      = grant_reg;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Bench for uart_tx_scheduler: a frame-timeline model checked every cycle, directed
// scenarios with literal expectations, and a randomized producer phase.
module tb_uart_tx_scheduler;
  localparam int CPB  = 4;
  localparam int FB   = 10;
  localparam int GAP  = 2;
  localparam int FLEN = 1 + CPB * FB + GAP;   // cycles from a start pulse to the next possible one

  logic clk;
  logic rst_n;
  int   cyc;
  int   vectors;
  int   errors;

  uart_tx_scheduler_if bus();

  uart_tx_scheduler #(.CLKS_PER_BIT(CPB), .FRAME_BITS(FB), .GAP_CLKS(GAP)) dut (
    .clk     (clk),
    .i_reset (rst_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Model: buffer contents plus the position within the current frame timeline
  // (ft = -1 idle, 0 = start-pulse cycle, FLEN-1 = last gap cycle).
  bit         mfull [2];
  logic [7:0] mbuf  [2];
  bit         mgrant;
  logic [7:0] mdata;
  int         ft;

  task automatic model_reset();
    mfull[0] = 1'b0; mfull[1] = 1'b0;
    mbuf[0]  = 8'h00; mbuf[1] = 8'h00;
    mgrant   = 1'b1;
    mdata    = 8'h00;
    ft       = -1;
  endtask

  task automatic model_step();
    bit f0, f1, go;
    int win;
    logic [7:0] wd;
    f0  = mfull[0];
    f1  = mfull[1];
    go  = (ft < 0 || ft == FLEN - 1) && (f0 || f1);
    win = (f0 && f1) ? (mgrant ? 0 : 1) : (f0 ? 0 : 1);
    wd  = mbuf[win];
    if (ft == 0) mfull[mgrant] = 1'b0;
    if (bus.i_req0_valid && !f0) begin mfull[0] = 1'b1; mbuf[0] = bus.i_req0_data; end
    if (bus.i_req1_valid && !f1) begin mfull[1] = 1'b1; mbuf[1] = bus.i_req1_data; end
    if (go) begin
      mgrant = win[0];
      mdata  = wd;
      ft     = 0;
    end else if (ft == FLEN - 1) begin
      ft = -1;
    end else if (ft >= 0) begin
      ft++;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step();
    end
  end

  // Cycle-by-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("start", {31'd0, bus.o_start_uart}, {31'd0, ft == 0});
      check("busy",  {31'd0, bus.o_busy},       {31'd0, ft >= 0});
      check("data",  {24'd0, bus.o_uart_data},  {24'd0, mdata});
      check("grant", {31'd0, bus.o_grant},      {31'd0, mgrant});
      check("ready0", {31'd0, bus.o_req0_ready}, {31'd0, !mfull[0]});
      check("ready1", {31'd0, bus.o_req1_ready}, {31'd0, !mfull[1]});
    end
  end

  // Transaction log and record of issued frames.
  logic [7:0] sd [$];
  bit         sg [$];
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.o_start_uart) begin
        sd.push_back(bus.o_uart_data);
        sg.push_back(bus.o_grant);
        $display("tx cycle %0d grant %0d data %02h", cyc, bus.o_grant, bus.o_uart_data);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_start(input int budget, output int c);
    c = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.o_start_uart) begin
        c = cyc;
        break;
      end
    end
    if (c < 0) begin
      vectors++;
      errors++;
      $display("FAIL start_timeout: no start pulse within %0d cycles (cycle %0d)", budget, cyc);
    end
  endtask

  task automatic wait_idle(input int budget);
    bit done;
    done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!bus.o_busy && bus.o_req0_ready && bus.o_req1_ready) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      vectors++;
      errors++;
      $display("FAIL idle_timeout: scheduler still busy after %0d cycles (cycle %0d)", budget, cyc);
    end
    tick();
  endtask

  initial begin
    int c1, c2, vcyc, n, stable, lowcnt, idx0, idx1;
    bit acc0, acc1, g1;
    logic [7:0] d1, first1;
    vectors = 0;
    errors  = 0;
    rst_n = 1'b0;
    bus.i_req0_valid = 1'b0; bus.i_req0_data = 8'h00;
    bus.i_req1_valid = 1'b0; bus.i_req1_data = 8'h00;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_busy",   {31'd0, bus.o_busy},       32'd0);
    check("rst_start",  {31'd0, bus.o_start_uart}, 32'd0);
    check("rst_data",   {24'd0, bus.o_uart_data},  32'h00);
    check("rst_grant",  {31'd0, bus.o_grant},      32'd1);
    check("rst_ready0", {31'd0, bus.o_req0_ready}, 32'd1);
    check("rst_ready1", {31'd0, bus.o_req1_ready}, 32'd1);
    tick();
    rst_n = 1'b1;

    // Idle: no spontaneous start pulse
    n = 0;
    repeat (100) begin
      @(negedge clk);
      if (bus.o_start_uart) n++;
    end
    check("idle_pulses", n, 32'd0);
    tick();

    // Single byte from requester 0
    bus.i_req0_valid = 1'b1; bus.i_req0_data = 8'hA5;
    vcyc = cyc;
    tick();
    bus.i_req0_valid = 1'b0;
    wait_start(20, c1);
    check("single_latency", c1 - vcyc, 32'd2);
    check("single_data",  {24'd0, bus.o_uart_data}, 32'hA5);
    check("single_grant", {31'd0, bus.o_grant},     32'd0);
    n = 0; stable = 0;
    for (int i = 0; i < 100 && bus.o_busy; i++) begin
      n++;
      if (i < 1 + CPB * FB && bus.o_uart_data == 8'hA5) stable++;
      @(negedge clk);
    end
    check("single_busy_cycles", n, 32'd43);
    check("single_data_stable", stable, 32'd41);
    tick();

    // Contention straight after reset: requester 0 first, then 1
    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();
    bus.i_req0_valid = 1'b1; bus.i_req0_data = 8'h11;
    bus.i_req1_valid = 1'b1; bus.i_req1_data = 8'h22;
    tick();
    bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
    wait_start(20, c1);
    g1 = bus.o_grant; d1 = bus.o_uart_data;
    wait_start(100, c2);
    check("cont_grant0", {31'd0, g1}, 32'd0);
    check("cont_data0",  {24'd0, d1}, 32'h11);
    check("cont_grant1", {31'd0, bus.o_grant},     32'd1);
    check("cont_data1",  {24'd0, bus.o_uart_data}, 32'h22);
    check("cont_spacing", c2 - c1, 32'd43);
    tick();

    // Fairness: both requesters keep their buffers full for 3 bytes each
    sd.delete(); sg.delete();
    idx0 = 0; idx1 = 0;
    bus.i_req0_valid = 1'b1; bus.i_req0_data = 8'h30;
    bus.i_req1_valid = 1'b1; bus.i_req1_data = 8'h40;
    for (int t = 0; t < 600 && (idx0 < 3 || idx1 < 3); t++) begin
      @(negedge clk);
      acc0 = bus.i_req0_valid && bus.o_req0_ready;
      acc1 = bus.i_req1_valid && bus.o_req1_ready;
      tick();
      if (acc0) begin
        idx0++;
        if (idx0 < 3) bus.i_req0_data = 8'(8'h30 + idx0); else bus.i_req0_valid = 1'b0;
      end
      if (acc1) begin
        idx1++;
        if (idx1 < 3) bus.i_req1_data = 8'(8'h40 + idx1); else bus.i_req1_valid = 1'b0;
      end
    end
    for (int t = 0; t < 400 && sd.size() < 6; t++) @(negedge clk);
    check("fair_count", sd.size(), 32'd6);
    for (int i = 0; i < 6 && i < sd.size(); i++) begin
      check("fair_grant", {31'd0, sg[i]}, i % 2);
      check("fair_data",  {24'd0, sd[i]}, (i % 2 ? 32'h40 : 32'h30) + i / 2);
    end
    wait_idle(200);

    // Backpressure: requester 1 holds valid with changing data while full
    bus.i_req0_valid = 1'b1; bus.i_req0_data = 8'h77;
    tick();
    bus.i_req0_valid = 1'b0;
    wait_start(20, c1);
    tick(); tick();
    first1 = 8'($urandom);
    bus.i_req1_valid = 1'b1; bus.i_req1_data = first1;
    lowcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i > 0 && !bus.o_req1_ready) lowcnt++;
      tick();
      bus.i_req1_data = 8'($urandom);
    end
    bus.i_req1_valid = 1'b0;
    check("bp_ready_low", lowcnt, 32'd19);
    wait_start(100, c2);
    check("bp_grant", {31'd0, bus.o_grant},     32'd1);
    check("bp_data",  {24'd0, bus.o_uart_data}, {24'd0, first1});
    wait_idle(200);

    // Randomized producers
    for (int i = 0; i < 400; i++) begin
      bus.i_req0_valid = ($urandom_range(0, 3) == 0);
      bus.i_req0_data  = 8'($urandom);
      bus.i_req1_valid = ($urandom_range(0, 3) == 0);
      bus.i_req1_data  = 8'($urandom);
      tick();
    end
    bus.i_req0_valid = 1'b0; bus.i_req1_valid = 1'b0;
    wait_idle(400);

    // Reset in the middle of a frame with requester 1 buffered
    bus.i_req0_valid = 1'b1; bus.i_req0_data = 8'h3C;
    tick();
    bus.i_req0_valid = 1'b0;
    wait_start(20, c1);
    bus.i_req1_valid = 1'b1; bus.i_req1_data = 8'h99;
    tick();
    bus.i_req1_valid = 1'b0;
    repeat (19) tick();
    check("mid_pre_busy", {31'd0, bus.o_busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("mid_busy",   {31'd0, bus.o_busy},       32'd0);
    check("mid_start",  {31'd0, bus.o_start_uart}, 32'd0);
    check("mid_ready0", {31'd0, bus.o_req0_ready}, 32'd1);
    check("mid_ready1", {31'd0, bus.o_req1_ready}, 32'd1);
    check("mid_grant",  {31'd0, bus.o_grant},      32'd1);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    bus.i_req0_valid = 1'b1; bus.i_req0_data = 8'hC3;
    vcyc = cyc;
    tick();
    bus.i_req0_valid = 1'b0;
    wait_start(20, c1);
    check("post_latency", c1 - vcyc, 32'd2);
    check("post_data",  {24'd0, bus.o_uart_data}, 32'hC3);
    check("post_grant", {31'd0, bus.o_grant},     32'd0);
    wait_idle(100);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
